// File: rtl/vga_sync_monitor_if.sv
// Sync taps, error-clear strobe and status outputs of the VGA timing monitor.
// master: generator/host side; slave: the monitor.
interface vga_sync_monitor_if;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        ERR_CLR;
    logic        LOCKED;
    logic [11:0] MEAS_H_TOTAL;
    logic [11:0] MEAS_H_SYNC;
    logic [10:0] MEAS_V_TOTAL;
    logic [10:0] MEAS_V_SYNC;
    logic [4:0]  ERR_FLAGS;
    logic [15:0] FRAME_COUNT;

    modport master (
        output VGA_HS, VGA_VS, ERR_CLR,
        input  LOCKED, MEAS_H_TOTAL, MEAS_H_SYNC, MEAS_V_TOTAL, MEAS_V_SYNC,
               ERR_FLAGS, FRAME_COUNT
    );

    modport slave (
        input  VGA_HS, VGA_VS, ERR_CLR,
        output LOCKED, MEAS_H_TOTAL, MEAS_H_SYNC, MEAS_V_TOTAL, MEAS_V_SYNC,
               ERR_FLAGS, FRAME_COUNT
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// Passive VGA sync checker: measures HS/VS timing, tracks lock, sticky errors, good-frame count.
// Edges acted on in the cycle detected, results visible next clock; never stalls its source.
module vga_sync_monitor #(
    parameter int H_TOTAL = 976,
    parameter int H_SYNC  = 88,
    parameter int V_TOTAL = 528,
    parameter int V_SYNC  = 3
) (
    input  logic              CLOCK_PIXEL,
    input  logic              RESET,
    vga_sync_monitor_if.slave mon
);
    localparam logic [11:0] H_TOT = 12'(H_TOTAL);
    localparam logic [11:0] H_TMO = 12'(H_TOTAL + 1);
    localparam logic [11:0] H_SYN = 12'(H_SYNC);
    localparam logic [10:0] V_TOT = 11'(V_TOTAL);
    localparam logic [10:0] V_SYN = 11'(V_SYNC);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;
    state_t state, state_nxt;

    logic        hs_d, vs_d, h_seen, frame_bad, locked;
    logic [11:0] h_cnt, meas_h_total, meas_h_sync;
    logic [10:0] v_cnt, meas_v_total, meas_v_sync;
    logic [4:0]  err_flags;
    logic [15:0] frame_count;

    logic hs_rise, hs_fall, vs_rise, vs_fall, frame_chk;
    logic e_h_total, e_h_sync, e_v_total, e_v_sync;
    logic h_err, v_err, frame_good, lock_lost;

    assign hs_rise   = mon.VGA_HS & ~hs_d;
    assign hs_fall   = ~mon.VGA_HS & hs_d;
    assign vs_rise   = mon.VGA_VS & ~vs_d;
    assign vs_fall   = ~mon.VGA_VS & vs_d;
    assign frame_chk = (state != ST_SEARCH);

    // The very first line after reset is partial, so line checks wait for a prior HS rise.
    assign e_h_total = h_seen & (hs_rise ? (h_cnt != H_TOT) : (h_cnt == H_TMO));
    assign e_h_sync  = h_seen & hs_fall & (h_cnt != H_SYN);
    // Frame timeout fires on the HS rise that would take the line count past V_TOTAL.
    assign e_v_total = frame_chk & (vs_rise ? (v_cnt != V_TOT)
                                            : (hs_rise & (v_cnt == V_TOT)));
    assign e_v_sync  = frame_chk & vs_fall & (v_cnt != V_SYN);

    assign h_err      = e_h_total | e_h_sync;
    assign v_err      = e_v_total | e_v_sync;
    assign frame_good = vs_rise & ~frame_bad & ~h_err & ~v_err;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEARCH:  if (vs_rise)         state_nxt = ST_MEASURE;
            ST_MEASURE: if (frame_good)      state_nxt = ST_LOCKED;
            ST_LOCKED:  if (h_err | v_err)   state_nxt = ST_MEASURE;
            default:                         state_nxt = ST_SEARCH;
        endcase
    end

    assign lock_lost = (state == ST_LOCKED) & (state_nxt != ST_LOCKED);

    always_ff @(posedge CLOCK_PIXEL or posedge RESET) begin
        if (RESET) begin
            state        <= ST_SEARCH;
            hs_d         <= 1'b0;
            vs_d         <= 1'b0;
            h_seen       <= 1'b0;
            frame_bad    <= 1'b0;
            locked       <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            meas_h_total <= '0;
            meas_h_sync  <= '0;
            meas_v_total <= '0;
            meas_v_sync  <= '0;
            err_flags    <= '0;
            frame_count  <= '0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt == ST_LOCKED);
            hs_d   <= mon.VGA_HS;
            vs_d   <= mon.VGA_VS;
            h_seen <= h_seen | hs_rise;

            if (hs_rise)                h_cnt <= 12'd1;
            else if (h_cnt != 12'hFFF)  h_cnt <= h_cnt + 12'd1;

            // A line starting together with VS belongs to the new frame as its line 1.
            if (vs_rise)                          v_cnt <= {10'd0, hs_rise};
            else if (hs_rise && v_cnt != 11'h7FF) v_cnt <= v_cnt + 11'd1;

            if (hs_rise) meas_h_total <= h_cnt;
            if (hs_fall) meas_h_sync  <= h_cnt;
            if (vs_rise) meas_v_total <= v_cnt;
            if (vs_fall) meas_v_sync  <= v_cnt;

            if (vs_rise)             frame_bad <= 1'b0;
            else if (h_err | v_err)  frame_bad <= 1'b1;

            // A fresh error in the clear cycle survives the clear.
            err_flags <= (mon.ERR_CLR ? 5'd0 : err_flags)
                       | {lock_lost, e_v_sync, e_v_total, e_h_sync, e_h_total};

            if (state == ST_LOCKED && frame_good) frame_count <= frame_count + 16'd1;
        end
    end

    assign mon.LOCKED       = locked;
    assign mon.MEAS_H_TOTAL = meas_h_total;
    assign mon.MEAS_H_SYNC  = meas_h_sync;
    assign mon.MEAS_V_TOTAL = meas_v_total;
    assign mon.MEAS_V_SYNC  = meas_v_sync;
    assign mon.ERR_FLAGS    = err_flags;
    assign mon.FRAME_COUNT  = frame_count;
endmodule
